pwm_capture: RTL

- Receive-side counterpart of the team's PWM generator. Samples an asynchronous PWM waveform and measures the period and high time between consecutive rising edges.
- Converts each measurement to a duty value in percent (0..100), on the same scale as the generator's duty input.
- Used for loopback self-test of the generator and for reading external PWM sources.

---
 rtl/pwm_capture.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// Measures period and high time of an asynchronous PWM input and reports duty in percent.
// Latency: valid rises CNT_W+8 cycles after the internal rising-edge detect.
// No backpressure: edges that arrive while the divider is busy are dropped and flagged via overrun.
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             pwm_in,
    output logic [7:0]       duty,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stuck,
    output logic             overrun
);
    localparam int NUM_W = CNT_W + 7;
    localparam int DC_W  = $clog2(NUM_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_MAX - CNT_W'(1);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t state, state_nx;

    logic             sync1, sync2, hist;
    logic             rise, timeout;
    logic [CNT_W-1:0] cnt_p, cnt_h;

    logic             div_busy;
    logic [DC_W-1:0]  div_cnt;
    logic [NUM_W-1:0] num_sh;
    logic [CNT_W-1:0] rem;
    logic [6:0]       quo;
    logic [CNT_W-1:0] op_p, op_h;
    logic             drop;

    logic             div_done, accept, dropped;
    logic [CNT_W:0]   rem_sh;
    logic             rem_ge;
    logic [CNT_W-1:0] rem_nx;
    logic [7:0]       quo_nx;

    assign rise = sync2 & ~hist;
    // Fires only on the cycle cnt_p steps into saturation, so a stalled input reports once.
    assign timeout = ~rise && (cnt_p == CNT_TO);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p <= '0;
            cnt_h <= '0;
        end else if (rise) begin
            cnt_p <= CNT_W'(1);
            cnt_h <= CNT_W'(1);
        end else begin
            if (cnt_p != CNT_MAX) cnt_p <= cnt_p + CNT_W'(1);
            if (sync2 && (cnt_h != CNT_MAX)) cnt_h <= cnt_h + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        div_done = 1'b0;
        accept   = 1'b0;
        dropped  = 1'b0;
        case (state)
            IDLE:    if (rise) state_nx = MEASURE;
            MEASURE: if (timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        div_done = div_busy && (div_cnt == DC_W'(1)) && !timeout;
        // The completing cycle frees the divider for an edge landing on the same cycle.
        if ((state == MEASURE) && rise) begin
            if (!div_busy || div_done) accept  = 1'b1;
            else                       dropped = 1'b1;
        end
    end

    always_comb begin
        rem_sh = {rem, num_sh[NUM_W-1]};
        rem_ge = (rem_sh >= {1'b0, op_p});
        rem_nx = rem_ge ? (rem_sh[CNT_W-1:0] - op_p) : rem_sh[CNT_W-1:0];
        quo_nx = {quo, rem_ge};
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            div_busy <= 1'b0;
            div_cnt  <= '0;
            num_sh   <= '0;
            rem      <= '0;
            quo      <= '0;
            op_p     <= '0;
            op_h     <= '0;
        end else if (timeout) begin
            div_busy <= 1'b0;
            div_cnt  <= '0;
        end else if (accept) begin
            div_busy <= 1'b1;
            div_cnt  <= DC_W'(NUM_W);
            num_sh   <= NUM_W'(cnt_h) * NUM_W'(100);
            rem      <= '0;
            quo      <= '0;
            op_p     <= cnt_p;
            op_h     <= cnt_h;
        end else if (div_busy) begin
            num_sh  <= {num_sh[NUM_W-2:0], 1'b0};
            rem     <= rem_nx;
            quo     <= quo_nx[6:0];
            div_cnt <= div_cnt - DC_W'(1);
            if (div_cnt == DC_W'(1)) div_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            duty      <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
            overrun   <= 1'b0;
            drop      <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (timeout) begin
                valid     <= 1'b1;
                stuck     <= 1'b1;
                duty      <= sync2 ? 8'd100 : 8'd0;
                period    <= '0;
                high_time <= '0;
                overrun   <= drop;
                drop      <= 1'b0;
            end else begin
                if (div_done) begin
                    valid     <= 1'b1;
                    stuck     <= 1'b0;
                    duty      <= quo_nx;
                    period    <= op_p;
                    high_time <= op_h;
                    overrun   <= drop;
                    drop      <= 1'b0;
                end
                if (dropped) drop <= 1'b1;
            end
        end
    end
endmodule
